// File: rtl/keypad_scanner.sv
// ============================================================================
// keypad_scanner : 4x4 matrix keypad column scanner with whole-scan debounce
// Revision 1.0   : initial release
// ============================================================================
`default_nettype none

module keypad_scanner #(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int DIV_W  = $clog2(SCAN_DIV);
    localparam int STAB_W = $clog2(DEBOUNCE_SCANS + 1);

    typedef enum logic [1:0] {CLS_NONE, CLS_SINGLE, CLS_MULTI} cls_t;
    typedef enum logic {IDLE, PRESSED} state_t;

    logic [3:0]        row_s1, row_s2;
    logic [DIV_W-1:0]  div;
    logic [1:0]        col_idx;
    logic [1:0]        cnt;
    logic              found;
    logic [3:0]        first_key;
    cls_t              prev_cls;
    logic [3:0]        prev_key;
    logic [STAB_W-1:0] stab;
    logic              eval_d;
    state_t            state;

    logic       slot_end;
    logic [3:0] pressed;
    logic [2:0] slot_cnt;
    logic [1:0] slot_row;
    logic [2:0] total;
    logic [3:0] scan_key;
    cls_t       scan_cls;
    logic       same;

    assign col      = ~(4'b0001 << col_idx);
    assign slot_end = (div == DIV_W'(SCAN_DIV - 1));
    assign pressed  = ~row_s2;

    always_comb begin
        slot_cnt = 3'd0;
        slot_row = 2'd0;
        for (int r = 0; r < 4; r++)
            slot_cnt = slot_cnt + {2'b00, pressed[r]};
        // Walk downwards so the lowest pressed row wins.
        for (int r = 3; r >= 0; r--)
            if (pressed[r]) slot_row = 2'(r);
    end

    // Scan summary including the slot being sampled right now.
    assign total    = {1'b0, cnt} + slot_cnt;
    assign scan_key = found ? first_key : {slot_row, col_idx};
    assign scan_cls = (total == 3'd0) ? CLS_NONE :
                      (total == 3'd1) ? CLS_SINGLE : CLS_MULTI;
    assign same     = (scan_cls == prev_cls) &&
                      ((scan_cls != CLS_SINGLE) || (scan_key == prev_key));

    always_ff @(posedge clk) begin
        if (rst) begin
            row_s1    <= 4'hF;
            row_s2    <= 4'hF;
            div       <= '0;
            col_idx   <= 2'd0;
            cnt       <= 2'd0;
            found     <= 1'b0;
            first_key <= 4'd0;
            prev_cls  <= CLS_NONE;
            prev_key  <= 4'd0;
            stab      <= '0;
            eval_d    <= 1'b0;
            state     <= IDLE;
            key_code  <= 4'd0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            eval_d    <= 1'b0;
            row_s1    <= row;
            row_s2    <= row_s1;

            if (slot_end) begin
                div     <= '0;
                col_idx <= col_idx + 2'd1;
                if (col_idx == 2'd3) begin
                    prev_cls <= scan_cls;
                    prev_key <= scan_key;
                    if (!same)
                        stab <= STAB_W'(1);
                    else if (stab != STAB_W'(DEBOUNCE_SCANS))
                        stab <= stab + STAB_W'(1);
                    eval_d <= 1'b1;
                    cnt    <= 2'd0;
                    found  <= 1'b0;
                end else begin
                    cnt <= (total >= 3'd2) ? 2'd2 : total[1:0];
                    if (!found && (slot_cnt != 3'd0)) begin
                        found     <= 1'b1;
                        first_key <= {slot_row, col_idx};
                    end
                end
            end else begin
                div <= div + DIV_W'(1);
            end

            // The FSM acts one cycle after the scan verdict is registered.
            if (eval_d && (stab == STAB_W'(DEBOUNCE_SCANS))) begin
                case (state)
                    IDLE: begin
                        if (prev_cls == CLS_SINGLE) begin
                            state     <= PRESSED;
                            key_code  <= prev_key;
                            key_valid <= 1'b1;
                            key_held  <= 1'b1;
                        end
                    end
                    PRESSED: begin
                        if (prev_cls == CLS_NONE) begin
                            state    <= IDLE;
                            key_held <= 1'b0;
                            stab     <= '0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_keypad_scanner.sv
// ============================================================================
// tb_keypad_scanner : scoreboard bench for keypad_scanner (SCAN_DIV=4, DEB=3)
// Revision 1.0      : initial release
// ============================================================================
`default_nettype none

module tb_keypad_scanner;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    logic [15:0] keys = 16'h0000;   // bit r*4+c = key at row r, column c
    int          cyc  = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic        chk_col = 1'b0;
    logic [3:0]  col_exp;

    typedef struct {
        logic [3:0] code;
        int         at;
    } exp_t;
    exp_t sb[$];

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3)) dut (
        .clk      (clk),
        .rst      (rst),
        .row      (row),
        .col      (col),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_held (key_held)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // Keypad matrix model: a pressed key pulls its row low while its column is driven.
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic expect_strobe(input logic [3:0] code, input int at);
        exp_t e;
        e.code = code;
        e.at   = at;
        sb.push_back(e);
    endtask

    // Monitor: every strobe must match the oldest pending expectation.
    always @(negedge clk) begin
        if (!rst && key_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_strobe", {28'd0, key_code}, 32'hDEAD);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("strobe_code", {28'd0, key_code}, {28'd0, e.code});
                check("strobe_cycle", cyc, e.at);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_col) begin
            col_exp = ~(4'b0001 << ((cyc / 4) % 4));
            check("col", {28'd0, col}, {28'd0, col_exp});
        end
    end

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_key_code", {28'd0, key_code}, 32'h0);
        check("rst_key_valid", {31'd0, key_valid}, 32'h0);
        check("rst_key_held", {31'd0, key_held}, 32'h0);
        check("rst_col", {28'd0, col}, 32'hE);
        rst     = 1'b0;
        chk_col = 1'b1;

        // Clean press of key 9 starting in scan 2, release in scan 6.
        wait_cyc(32);
        keys = 16'h0200;
        expect_strobe(4'h9, 32 + 49);
        wait_cyc(80);
        check("held_before_accept", {31'd0, key_held}, 32'h0);
        wait_cyc(82);
        check("held_after_press", {31'd0, key_held}, 32'h1);
        check("code_after_press", {28'd0, key_code}, 32'h9);
        wait_cyc(96);
        keys = 16'h0000;
        wait_cyc(144);
        check("held_before_release", {31'd0, key_held}, 32'h1);
        wait_cyc(145);
        check("held_after_release", {31'd0, key_held}, 32'h0);

        // Bounce: 2 scans on, 1 off, 2 on, then released.
        wait_cyc(160); keys = 16'h0200;
        wait_cyc(192); keys = 16'h0000;
        wait_cyc(208); keys = 16'h0200;
        wait_cyc(240); keys = 16'h0000;
        wait_cyc(287);
        check("held_after_bounce", {31'd0, key_held}, 32'h0);
        check("code_holds_after_bounce", {28'd0, key_code}, 32'h9);

        // Keys 0 and 5 together, then release 5 leaving key 0.
        wait_cyc(288); keys = 16'h0021;
        wait_cyc(384);
        check("held_during_multi", {31'd0, key_held}, 32'h0);
        keys = 16'h0001;
        expect_strobe(4'h0, 384 + 49);
        wait_cyc(434);
        check("held_key0", {31'd0, key_held}, 32'h1);
        check("code_key0", {28'd0, key_code}, 32'h0);
        wait_cyc(448); keys = 16'h0000;
        wait_cyc(496);
        check("held_key0_before_release", {31'd0, key_held}, 32'h1);
        wait_cyc(497);
        check("held_key0_released", {31'd0, key_held}, 32'h0);

        // Reset in the middle of a key-9 debounce.
        wait_cyc(512); keys = 16'h0200;
        wait_cyc(536);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_key_held", {31'd0, key_held}, 32'h0);
        check("midrst_key_code", {28'd0, key_code}, 32'h0);
        check("midrst_col", {28'd0, col}, 32'hE);
        expect_strobe(4'h9, 49);
        wait_cyc(48);
        check("midrst_held_before", {31'd0, key_held}, 32'h0);
        wait_cyc(50);
        check("midrst_held_after", {31'd0, key_held}, 32'h1);
        check("midrst_code_after", {28'd0, key_code}, 32'h9);

        // Switch to key E while held: no strobe until released and re-pressed.
        wait_cyc(64); keys = 16'h4000;
        wait_cyc(120);
        check("switch_code_kept", {28'd0, key_code}, 32'h9);
        check("switch_still_held", {31'd0, key_held}, 32'h1);
        wait_cyc(128); keys = 16'h0000;
        wait_cyc(176);
        check("switch_held_before_release", {31'd0, key_held}, 32'h1);
        wait_cyc(177);
        check("switch_released", {31'd0, key_held}, 32'h0);
        wait_cyc(192); keys = 16'h4000;
        expect_strobe(4'hE, 192 + 49);
        wait_cyc(242);
        check("repress_held", {31'd0, key_held}, 32'h1);
        check("repress_code", {28'd0, key_code}, 32'hE);
        wait_cyc(256); keys = 16'h0000;
        wait_cyc(320);
        check("scoreboard_drained", sb.size(), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
